// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a bank of 8-bit registers, one write per clock,
// with bounded locked runs. Optional saturating write counter under ARB_WRCNT_EN.
module reg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int NREGS    = 4,
    parameter int AW       = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*8-1:0]    wr_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic [NREGS-1:0]     reg_en,
    output logic [7:0]           reg_in,
    output logic                 busy
`ifdef ARB_WRCNT_EN
    ,
    output logic [15:0]          wr_count
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            r_state, w_state_next;
    logic [PW-1:0]     r_ptr, w_ptr_next;
    logic [PW-1:0]     r_owner, w_owner_next;
    logic [3:0]        r_run, w_run_next;
    logic [NREQ-1:0]   r_grant, w_grant_next;
    logic [NREQ-1:0]   r_ack, w_ack_next;
    logic [NREGS-1:0]  r_reg_en, w_reg_en_next;
    logic [7:0]        r_reg_in, w_reg_in_next;
    logic              r_busy, w_busy_next;

    logic [AW-1:0]     w_addr [NREQ];
    logic [7:0]        w_data [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr[gi] = wr_addr[gi*AW +: AW];
            assign w_data[gi] = wr_data[gi*8 +: 8];
        end
    endgenerate

    // Rotate requests so bit 0 is the current round-robin head, then take the lowest set bit.
    logic [2*NREQ-1:0] w_dbl;
    logic [2*NREQ-1:0] w_rot;
    logic              w_found;
    logic [PW-1:0]     w_win;
    int                w_sum;

    assign w_dbl = {req, req};
    assign w_rot = w_dbl >> r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = int'(r_ptr) + k;
                if (w_sum >= NREQ) w_sum = w_sum - NREQ;
                w_win   = PW'(w_sum);
            end
        end
    end

    logic          w_do_write;
    logic [PW-1:0] w_sel;

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_owner_next  = r_owner;
        w_run_next    = r_run;
        w_grant_next  = '0;
        w_ack_next    = '0;
        w_reg_en_next = '0;
        w_reg_in_next = 8'h00;
        w_busy_next   = 1'b0;
        w_do_write    = 1'b0;
        w_sel         = r_owner;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_do_write   = 1'b1;
                    w_sel        = w_win;
                    w_owner_next = w_win;
                    w_run_next   = 4'd1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (req[r_owner] && lock[r_owner] && (int'(r_run) < LOCK_MAX)) begin
                    w_do_write = 1'b1;
                    w_run_next = r_run + 4'd1;
                end else begin
                    w_ptr_next   = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
                    w_run_next   = 4'd0;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Out-of-range targets still ack the requester but enable nothing.
        if (w_do_write) begin
            w_grant_next[w_sel] = 1'b1;
            w_ack_next[w_sel]   = 1'b1;
            w_busy_next         = 1'b1;
            w_reg_in_next       = w_data[w_sel];
            if (int'(w_addr[w_sel]) < NREGS) w_reg_en_next[w_addr[w_sel]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_run    <= 4'd0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_reg_en <= '0;
            r_reg_in <= 8'h00;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_owner  <= w_owner_next;
            r_run    <= w_run_next;
            r_grant  <= w_grant_next;
            r_ack    <= w_ack_next;
            r_reg_en <= w_reg_en_next;
            r_reg_in <= w_reg_in_next;
            r_busy   <= w_busy_next;
        end
    end

    assign grant  = r_grant;
    assign ack    = r_ack;
    assign reg_en = r_reg_en;
    assign reg_in = r_reg_in;
    assign busy   = r_busy;

`ifdef ARB_WRCNT_EN
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count <= 16'h0000;
        end else if ((|r_reg_en) && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'h0001;
        end
    end

    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of arbitration and a modelled register bank.
module tb_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int NREGS    = 3;
    localparam int AW       = 2;
    localparam int LOCK_MAX = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ*AW-1:0]  wr_addr;
    logic [NREQ*8-1:0]   wr_data;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     ack;
    logic [NREGS-1:0]    reg_en;
    logic [7:0]          reg_in;
    logic                busy;
`ifdef ARB_WRCNT_EN
    logic [15:0]         wr_count;
`endif

    int total = 0;
    int bad   = 0;

    reg_write_arbiter #(
        .NREQ(NREQ), .NREGS(NREGS), .AW(AW), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .grant(grant), .ack(ack), .reg_en(reg_en), .reg_in(reg_in), .busy(busy)
`ifdef ARB_WRCNT_EN
        , .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    // Register bank driven by the arbiter outputs.
    logic [7:0] tb_bank [NREGS] = '{default: 8'h00};
    always @(posedge clk) begin
        for (int j = 0; j < NREGS; j++)
            if (reg_en[j]) tb_bank[j] <= reg_in;
    end

    // Reference model state.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_run   = 0;
    int         e_count = 0;
    logic [3:0] e_grant = '0;
    logic [3:0] e_ack   = '0;
    logic [2:0] e_reg_en = '0;
    logic [7:0] e_reg_in = '0;
    logic       e_busy  = 1'b0;
    logic [7:0] e_bank [NREGS] = '{default: 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        int a;
        if (e_reg_en != 0) begin
            for (int j = 0; j < NREGS; j++)
                if (e_reg_en[j]) e_bank[j] = e_reg_in;
            if (e_count < 65535) e_count++;
        end
        if (reset) begin
            e_count = 0;
            m_owner = -1; m_ptr = 0; m_run = 0;
            e_grant = '0; e_ack = '0; e_reg_en = '0; e_reg_in = '0; e_busy = 1'b0;
            return;
        end
        w = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) m_run = 1;
        end else if (req[m_owner] && lock[m_owner] && m_run < LOCK_MAX) begin
            w = m_owner;
            m_run++;
        end else begin
            m_ptr = (m_owner + 1) % NREQ;
            m_run = 0;
        end
        m_owner = w;
        if (w < 0) begin
            e_grant = '0; e_ack = '0; e_reg_en = '0; e_reg_in = '0; e_busy = 1'b0;
        end else begin
            a        = int'(wr_addr[w*AW +: AW]);
            e_grant  = 4'(1 << w);
            e_ack    = 4'(1 << w);
            e_reg_en = (a < NREGS) ? 3'(1 << a) : 3'b000;
            e_reg_in = wr_data[w*8 +: 8];
            e_busy   = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("grant",  32'(grant),  32'(e_grant));
        chk("ack",    32'(ack),    32'(e_ack));
        chk("reg_en", 32'(reg_en), 32'(e_reg_en));
        chk("reg_in", 32'(reg_in), 32'(e_reg_in));
        chk("busy",   32'(busy),   32'(e_busy));
        for (int j = 0; j < NREGS; j++) chk("bank", 32'(tb_bank[j]), 32'(e_bank[j]));
`ifdef ARB_WRCNT_EN
        chk("wr_count", 32'(wr_count), 32'(e_count));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        $display("t=%0t req=%b lock=%b grant=%b ack=%b reg_en=%b reg_in=%h busy=%b",
                 $time, req, lock, grant, ack, reg_en, reg_in, busy);
    endtask

    task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [7:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*8 +: 8]   = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; lock = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; lock = '0; wr_addr = '0; wr_data = '0;
        step();
        step();
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        reset = 1'b0;

        // Single write to reg2.
        set_rq(0, 2'd2, 8'h0A);
        req = 4'b0001;
        step();
        chk("single ack",    32'(ack),    32'h1);
        chk("single grant",  32'(grant),  32'h1);
        chk("single reg_en", 32'(reg_en), 32'h4);
        chk("single reg_in", 32'(reg_in), 32'h0A);
        chk("single busy",   32'(busy),   32'h1);
        req = 4'b0000;
        step();
        chk("single idle ack", 32'(ack), 32'h0);
        chk("single bank2",    32'(tb_bank[2]), 32'h0A);

        // Round robin with all requesters active.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_rq(i, AW'(i % NREGS), 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rr ack", 32'(ack), (k % 2 == 0) ? 32'(1 << ((k / 2) % NREQ)) : 32'h0);
            if (k % 2 == 0) chk("rr data", 32'(reg_in), 32'(8'h10 + (k / 2) % NREQ));
        end
        req = 4'b0000;
        step();

        // Locked run by requester 1 while requester 2 waits.
        do_reset();
        set_rq(2, 2'd2, 8'h99);
        req  = 4'b0110;
        lock = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            set_rq(1, 2'd0, 8'(8'h21 + k));
            step();
            if (k < LOCK_MAX) begin
                chk("lock ack",    32'(ack),    32'h2);
                chk("lock reg_in", 32'(reg_in), 32'(8'h21 + k));
            end else if (k == LOCK_MAX) begin
                chk("lock gap ack", 32'(ack), 32'h0);
            end else begin
                chk("lock next ack", 32'(ack), 32'h4);
            end
        end
        req = '0; lock = '0;
        step();
        step();

        // Out-of-range target is acked but dropped.
        set_rq(0, 2'd3, 8'h77);
        req = 4'b0001;
        step();
        chk("oor ack",    32'(ack),    32'h1);
        chk("oor reg_en", 32'(reg_en), 32'h0);
        req = '0;
        step();

        // Reset during a WRITE cycle.
        do_reset();
        set_rq(2, 2'd1, 8'h55);
        req = 4'b0100;
        step();
        chk("midrst reg_en", 32'(reg_en), 32'h2);
        reset = 1'b1; req = '0;
        step();
        chk("midrst bank1", 32'(tb_bank[1]), 32'h55);
        chk("midrst grant", 32'(grant), 32'h0);
        reset = 1'b0;
        req = 4'b1111;
        step();
        chk("midrst restart grant", 32'(grant), 32'h1);
        req = '0;
        step();
        step();

`ifdef ARB_WRCNT_EN
        do_reset();
        set_rq(0, 2'd0, 8'h3C);
        req = 4'b0001;
        for (int k = 0; k < 10; k++) step();
        req = '0;
        step();
        chk("count five", 32'(wr_count), 32'd5);
        dut.r_wr_count = 16'hFFFE;
        e_count = 65534;
        req = 4'b0001;
        for (int k = 0; k < 6; k++) step();
        req = '0;
        step();
        chk("count saturate", 32'(wr_count), 32'hFFFF);
`endif

        // Random traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            req   = NREQ'($urandom);
            lock  = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_rq(i, AW'($urandom_range(0, 3)), 8'($urandom));
            step();
        end
        reset = 1'b0; req = '0; lock = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares write access to a bank of 8-bit `register` instances among NREQ requesters (ALU result, bus load, PC/IR loader, debug).
- Drives the bank's per-register `en` inputs and one shared 8-bit `in` bus.
- Guarantees at most one register write per clock.
- Supports a lock mode that lets one requester issue back-to-back writes up to a bounded run length.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NREGS, 4, number of registers in the bank (2..16).
- AW, 2, register address width (ceil log2 NREGS).
- LOCK_MAX, 4, maximum consecutive writes by one locked requester (1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  requester i wants one write.
- lock  in  NREQ  requester i requests to keep its grant after the current write.
- wr_addr  in  NREQ*AW  requester i target register, at [i*AW +: AW].
- wr_data  in  NREQ*8  requester i write data, at [i*8 +: 8].
- grant  out  NREQ  one-hot current owner; 0 when idle.
- ack  out  NREQ  one-cycle pulse: requester i's write occurs this cycle.
- reg_en  out  NREGS  one-hot enable to register bank `en` inputs.
- reg_in  out  8  shared data to register bank `in` inputs.
- busy  out  1  high while in WRITE.

Behaviour:
- Reset values (reset sampled high at an edge): state=IDLE; grant, ack, reg_en, busy = 0; reg_in=0x00; rr pointer ptr=0; run counter=0.
- All outputs are flop outputs; no combinational input-to-output paths.
- States are IDLE and WRITE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner w is the first set req bit searching from ptr upward, wrapping modulo NREQ.
  - At the edge: latch wr_addr[w] and wr_data[w]; grant=onehot(w); run=1; go to WRITE.
- WRITE (one cycle per write):
  - reg_en = onehot(latched addr); reg_in = latched data; ack[w]=1; busy=1.
  - The bank register captures at the edge that ends this cycle.
  - If latched addr >= NREGS: reg_en=0, and ack is still pulsed (the write is dropped).
- Leaving WRITE:
  - Continue condition: req[w] && lock[w] && run<LOCK_MAX, all sampled during this WRITE cycle.
  - If the continue condition holds: latch new wr_addr[w]/wr_data[w], run=run+1, stay in WRITE. This gives a back-to-back write next cycle with no bubble.
  - Otherwise: ptr=(w+1) mod NREQ, grant=0, run=0, go to IDLE.
  - There is always one IDLE cycle between different owners.
- Latency: req high at edge k in IDLE, then ack and reg_en during cycle k+1, then the register is updated at edge k+2.
- Requester rules:
  - Addr and data need only be valid at the sampling edge.
  - A non-locked requester keeping req high through its ack cycle is a new request, arbitrated in the next IDLE at its round-robin position.
  - Requests from other requesters during WRITE are held off, never lost while req remains high.
- Simultaneous events:
  - lock without req is ignored.
  - req dropped during a locked run ends the run normally.
  - Changing lock of non-owners has no effect.
- Reset mid-WRITE: the write whose reg_en was already high in that cycle completes at that edge. All outputs are 0 the next cycle; ptr returns to 0.
- Fairness: with all req high and no lock, the grant order is 0,1,…,NREQ-1,0,… with one write every 2 cycles.

Optional Feature:
- Macro: ARB_WRCNT_EN.
- When defined:
  - Adds output port wr_count [15:0], which increments at each WRITE cycle end where reg_en!=0.
  - The counter saturates at 0xFFFF and is cleared to 0 by reset.
  - Dropped out-of-range writes are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single write, NREQ=4 NREGS=4:
  - Stimulus: req=0001, wr_addr[0]=2, wr_data[0]=0x0A for one cycle.
  - Response: next cycle ack=0001, grant=0001, reg_en=0100, reg_in=0x0A, busy=1.
  - Then IDLE with all outputs 0, and bank reg2 reads 0x0A.
- Round robin:
  - Stimulus: out of reset, req=1111 held, data i = 0x10+i.
  - Response: ack order 0,1,2,3,0 on alternate cycles.
  - Each reg_in matches the owner's data; ptr wraps 3 to 0.
- Lock run, LOCK_MAX=4:
  - Stimulus: req1 and lock1 held with 6 data values 0x21..0x26; req2 also high.
  - Response: 4 consecutive WRITE cycles with ack=0010 (0x21..0x24).
  - Then one IDLE cycle, then ack=0100 (requester 2 served before requester 1 resumes).
- Out-of-range address:
  - Stimulus: NREGS=3, wr_addr=3.
  - Response: ack pulsed, reg_en=000, bank unchanged, wr_count unchanged (with ARB_WRCNT_EN).
- Reset mid-WRITE:
  - Stimulus: assert reset during the WRITE cycle of requester 2 (addr1, 0x55).
  - Response: reg1=0x55 after that edge; next cycle grant, ack, reg_en, busy = 0.
  - Next arbitration starts from ptr=0.
- ARB_WRCNT_EN:
  - Stimulus: 5 valid writes.
  - Response: wr_count=5.
  - Preload near saturation, then issue 3 writes: wr_count holds at 0xFFFF.
